// File: rtl/eda_neigh_push_ctrl.sv
// eda_neigh_push_ctrl: serialises an 8-neighbour push mask into a FIFO of
// pixel addresses (row*N + col) for the event-driven expansion loop.
// Optional build macro EDA_BOUND_CHECK_EN: drops neighbours that fall
// outside the M x N image at load time instead of enqueuing them.
module eda_neigh_push_ctrl #(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int ADDR_WIDTH = $clog2(M*N),
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        load,
  input  logic [7:0]                  push_mask,
  input  logic [ADDR_WIDTH-1:0]       center_addr,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  iterated_idx,
  input  logic                        pop_req,
  output logic [ADDR_WIDTH-1:0]       pop_addr,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, SERIAL} state_t;

  state_t                state_r;
  logic [7:0]            rem_r;
  logic [ADDR_WIDTH-1:0] center_r;
  logic [7:0]            iter_r;
  logic                  done_r;
  logic [ADDR_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  logic [2:0]            sel_idx_s;
  logic [7:0]            sel_onehot_s;
  logic [7:0]            rem_next_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] enq_addr_s;
  logic [7:0]            load_keep_s;
  logic [7:0]            load_drop_s;

  // Window position of mask bit k: the centre (position 4) is skipped.
  function automatic int bit_to_pos(input logic [2:0] k);
    return (k < 3'd4) ? int'(k) : int'(k) + 1;
  endfunction

  // Neighbour address, wrapping modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] neigh_addr(input logic [ADDR_WIDTH-1:0] c,
                                                       input logic [2:0] k);
    int p;
    int off;
    p   = bit_to_pos(k);
    off = (p / 3 - 1) * N + (p % 3 - 1);
    return c + off[ADDR_WIDTH-1:0];
  endfunction

`ifdef EDA_BOUND_CHECK_EN
  // True when the neighbour for bit k lies inside the image.
  function automatic logic in_image(input logic [ADDR_WIDTH-1:0] c, input logic [2:0] k);
    int p;
    int r;
    int cl;
    p  = bit_to_pos(k);
    r  = int'(c) / N + p / 3 - 1;
    cl = int'(c) % N + p % 3 - 1;
    return (r >= 0) && (r < M) && (cl >= 0) && (cl < N);
  endfunction

  // Split the incoming mask into bits to serialise and bits dropped at the border.
  always_comb begin
    load_keep_s = 8'd0;
    load_drop_s = 8'd0;
    for (int i = 0; i < 8; i++) begin
      load_keep_s[i] = push_mask[i] & in_image(center_addr, 3'(i));
      load_drop_s[i] = push_mask[i] & ~in_image(center_addr, 3'(i));
    end
  end
`else
  // Without border filtering every requested neighbour is serialised.
  always_comb begin
    load_keep_s = push_mask;
    load_drop_s = 8'd0;
  end
`endif

  // Pick the lowest pending mask bit and derive FIFO handshakes.
  always_comb begin
    sel_idx_s = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      sel_idx_s = rem_r[i] ? 3'(i) : sel_idx_s;
    end
    sel_onehot_s = 8'd1 << sel_idx_s;
    rem_next_s   = rem_r & ~sel_onehot_s;
    full_s       = (count_r == CW'(FIFO_DEPTH));
    empty_s      = (count_r == CW'(0));
    push_s       = (state_r == SERIAL) && (rem_r != 8'd0) && !full_s;
    pop_s        = pop_req && !empty_s;
    enq_addr_s   = neigh_addr(center_r, sel_idx_s);
  end

  // Control FSM: capture a mask in IDLE, drain it one bit per cycle in SERIAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      rem_r    <= 8'd0;
      center_r <= '0;
      iter_r   <= 8'd0;
      done_r   <= 1'b0;
    end else if (flush) begin
      state_r <= IDLE;
      rem_r   <= 8'd0;
      iter_r  <= 8'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            rem_r    <= load_keep_s;
            center_r <= center_addr;
            iter_r   <= load_drop_s;
            if (load_keep_s != 8'd0) begin
              state_r <= SERIAL;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        SERIAL: begin
          if (!full_s) begin
            rem_r  <= rem_next_s;
            iter_r <= iter_r | sel_onehot_s;
            if (rem_next_s == 8'd0) begin
              state_r <= IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= enq_addr_s;
    end
  end

  assign busy         = (state_r == SERIAL);
  assign done         = done_r;
  assign iterated_idx = iter_r;
  assign pop_addr     = mem_r[rd_ptr_r];
  assign empty        = empty_s;
  assign full         = full_s;
  assign count        = count_r;

endmodule

// File: tb/tb_eda_neigh_push_ctrl.sv
// Self-checking bench for eda_neigh_push_ctrl (M=N=16, FIFO_DEPTH=16):
// directed scenarios plus randomized traffic against a queue-based model.
module tb_eda_neigh_push_ctrl;
  localparam int M  = 16;
  localparam int N  = 16;
  localparam int AW = 8;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          load;
  logic [7:0]    push_mask;
  logic [AW-1:0] center_addr;
  logic          busy;
  logic          done;
  logic [7:0]    iterated_idx;
  logic          pop_req;
  logic [AW-1:0] pop_addr;
  logic          empty;
  logic          full;
  logic [4:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_busy;
  bit m_done;
  int m_rem;
  int m_center;
  int m_iter;
  int q[$];

  eda_neigh_push_ctrl #(.M(M), .N(N), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .load(load),
    .push_mask(push_mask), .center_addr(center_addr), .busy(busy), .done(done),
    .iterated_idx(iterated_idx), .pop_req(pop_req), .pop_addr(pop_addr),
    .empty(empty), .full(full), .count(count)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int win_pos(int k);
    return (k < 4) ? k : k + 1;
  endfunction

  function automatic int nb_addr(int c, int k);
    int p;
    p = win_pos(k);
    return (c + (p / 3 - 1) * N + (p % 3 - 1)) & ((1 << AW) - 1);
  endfunction

  function automatic bit nb_inside(int c, int k);
    int p;
    int r;
    int col;
    p   = win_pos(k);
    r   = c / N + p / 3 - 1;
    col = c % N + p % 3 - 1;
    return (r >= 0) && (r < M) && (col >= 0) && (col < N);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_rem = 0; m_iter = 0; m_center = 0;
    q.delete();
  endtask

  // One clock edge of the specified behaviour, given the inputs of that cycle.
  task automatic model_step(bit f, bit l, int m, int c, bit p);
    bit was_full;
    bit nd;
    int b;
    if (f) begin
      m_busy = 0; m_rem = 0; m_iter = 0; m_done = 0;
      q.delete();
      return;
    end
    was_full = (q.size() == D);
    nd = 0;
    if (p && q.size() > 0) void'(q.pop_front());
    if (!m_busy) begin
      if (l) begin
        m_center = c; m_rem = m; m_iter = 0;
`ifdef EDA_BOUND_CHECK_EN
        for (int k = 0; k < 8; k++) begin
          if (((m >> k) & 1) == 1 && !nb_inside(c, k)) begin
            m_rem  = m_rem & ~(1 << k);
            m_iter = m_iter | (1 << k);
          end
        end
`endif
        if (m_rem == 0) nd = 1;
        else m_busy = 1;
      end
    end else begin
      b = 0;
      while (((m_rem >> b) & 1) == 0) b++;
      if (!was_full) begin
        q.push_back(nb_addr(m_center, b));
        m_rem  = m_rem & ~(1 << b);
        m_iter = m_iter | (1 << b);
        if (m_rem == 0) begin
          m_busy = 0;
          nd = 1;
        end
      end
    end
    m_done = nd;
  endtask

  task automatic compare_all();
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
    check_eq("iterated_idx", iterated_idx, m_iter);
    check_eq("count", count, q.size());
    check_eq("empty", empty, q.size() == 0);
    check_eq("full", full, q.size() == D);
    if (q.size() > 0) check_eq("pop_addr", pop_addr, q[0]);
  endtask

  // Drive one cycle's inputs, advance the model, sample at the next falling edge.
  task automatic cycle(bit f, bit l, int m, int c, bit p);
    flush = f; load = l; push_mask = m[7:0]; center_addr = c[AW-1:0]; pop_req = p;
    model_step(f, l, m, c, p);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string tag, int maxc);
    int n;
    n = 0;
    while (m_busy && n < maxc) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    if (m_busy) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; load = 1'b0; push_mask = 8'd0;
    center_addr = '0; pop_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // Mask 0x81 around 0x22, first load right after reset release
    cycle(0, 1, 8'h81, 8'h22, 0);
    check_eq("t34_busy", busy, 1'b1);
    cycle(0, 0, 0, 0, 0);
    check_eq("t34_head", pop_addr, 8'h11);
    cycle(0, 0, 0, 0, 0);
    check_eq("t34_done", done, 1'b1);
    check_eq("t34_iter", iterated_idx, 8'h81);
    check_eq("t34_count", count, 5'd2);
    cycle(0, 0, 0, 0, 1);
    check_eq("t34_second", pop_addr, 8'h33);
    idle(1);

    // Empty mask: done pulse the next cycle without ever going busy
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'h00, 8'h40, 0);
    check_eq("t35_done", done, 1'b1);
    check_eq("t35_busy", busy, 1'b0);
    idle(1);
    check_eq("t35_done_clear", done, 1'b0);

    // Fill to full, then a stalled third load released by one pop
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'hFF, 8'h55, 0);
    wait_idle("t36a", 20);
    idle(1);
    cycle(0, 1, 8'hFF, 8'h55, 0);
    wait_idle("t36b", 20);
    idle(1);
    check_eq("t36_count", count, 5'd16);
    check_eq("t36_full", full, 1'b1);
    cycle(0, 1, 8'h01, 8'h55, 0);
    idle(3);
    check_eq("t36_stall_busy", busy, 1'b1);
    check_eq("t36_stall_iter", iterated_idx, 8'h00);
    cycle(0, 0, 0, 0, 1);
    idle(1);
    check_eq("t36_done", done, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("t36_tail", pop_addr, 8'h44);
      cycle(0, 0, 0, 0, 1);
    end

    // Asynchronous reset in the middle of serialisation
    cycle(0, 1, 8'hFF, 8'h55, 0);
    idle(3);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("t37_busy", busy, 1'b0);
    check_eq("t37_count", count, 5'd0);
    check_eq("t37_empty", empty, 1'b1);
    check_eq("t37_iter", iterated_idx, 8'h00);
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    cycle(0, 1, 8'h02, 8'h22, 0);
    wait_idle("t37", 10);
    idle(1);
    check_eq("t37_entry", pop_addr, 8'h12);
    check_eq("t37_count1", count, 5'd1);

`ifdef EDA_BOUND_CHECK_EN
    // Corner pixel: only the three in-image neighbours are queued
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'hFF, 8'h00, 0);
    idle(3);
    check_eq("t38_done", done, 1'b1);
    check_eq("t38_iter", iterated_idx, 8'hFF);
    check_eq("t38_count", count, 5'd3);
    check_eq("t38_first", pop_addr, 8'h01);
`endif

    // Randomized traffic with varying pop pressure
    cycle(1, 0, 0, 0, 0);
    for (int seg = 0; seg < 15; seg++) begin
      int pop_pct;
      pop_pct = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 59) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 255),
              $urandom_range(0, 255),
              $urandom_range(0, 99) < pop_pct);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
